// File: rtl/regfile_nr2w_scrub.sv
// Multi-read, dual-write register file with write-to-read bypass
// and a one-entry-per-cycle scrub engine that zeroes the array.
module regfile_nr2w_scrub #(
  parameter int BIT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_RD     = 4,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         gwe,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rsel,
  output logic [NUM_RD*BIT_WIDTH-1:0]  rdata,
  input  logic [ADDR_WIDTH-1:0]        w1sel,
  input  logic [BIT_WIDTH-1:0]         w1data,
  input  logic                         w1e,
  input  logic [ADDR_WIDTH-1:0]        w2sel,
  input  logic [BIT_WIDTH-1:0]         w2data,
  input  logic                         w2e,
  input  logic                         clr,
  output logic                         busy,
  output logic [ADDR_WIDTH-1:0]        scrub_ptr
);

  localparam int RAM_SIZE = 2 ** ADDR_WIDTH;

  localparam logic [0:0] SCRUB = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [BIT_WIDTH-1:0]  mem_q [RAM_SIZE];

  logic busy_w;
  logic wr_act;

  assign busy_w    = (state_q == SCRUB);
  assign busy      = busy_w;
  assign scrub_ptr = ptr_q;
  assign wr_act    = ~busy_w & gwe & ~clr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (gwe) begin
      unique case (state_q)
        SCRUB: begin
          if (ptr_q == LAST) begin
            state_d = READY;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        READY: begin
          if (clr) begin
            state_d = SCRUB;
            ptr_d   = '0;
          end
        end
        default: begin
          state_d = SCRUB;
          ptr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCRUB;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array is deliberately outside reset; w2 is written last so it wins.
  always_ff @(posedge clk) begin
    if (!rst && gwe) begin
      if (busy_w) begin
        mem_q[ptr_q] <= '0;
      end else if (!clr) begin
        if (w1e) mem_q[w1sel] <= w1data;
        if (w2e) mem_q[w2sel] <= w2data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0]  val;

    assign addr = rsel[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      val = mem_q[addr];
      if (BYPASS != 0 && wr_act) begin
        if (w2e && w2sel == addr) begin
          val = w2data;
        end else if (w1e && w1sel == addr) begin
          val = w1data;
        end
      end
      if (busy_w) val = '0;
    end

    assign rdata[k*BIT_WIDTH +: BIT_WIDTH] = val;
  end

endmodule

// File: tb/tb_regfile_nr2w_scrub.sv
// Directed bench: two instances (bypass on/off) share one stimulus.
module tb_regfile_nr2w_scrub;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic [11:0] rsel;
  logic [2:0]  w1sel, w2sel;
  logic [15:0] w1data, w2data;
  logic        w1e, w2e, clr;

  logic [63:0] rd_b, rd_n;
  logic        busy_b, busy_n;
  logic [2:0]  ptr_b, ptr_n;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_nr2w_scrub #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .gwe(gwe), .rsel(rsel), .rdata(rd_b),
    .w1sel(w1sel), .w1data(w1data), .w1e(w1e),
    .w2sel(w2sel), .w2data(w2data), .w2e(w2e),
    .clr(clr), .busy(busy_b), .scrub_ptr(ptr_b)
  );

  regfile_nr2w_scrub #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .gwe(gwe), .rsel(rsel), .rdata(rd_n),
    .w1sel(w1sel), .w1data(w1data), .w1e(w1e),
    .w2sel(w2sel), .w2data(w2data), .w2e(w2e),
    .clr(clr), .busy(busy_n), .scrub_ptr(ptr_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd4(input logic [2:0] a0, input logic [2:0] a1,
                     input logic [2:0] a2, input logic [2:0] a3);
    rsel = {a3, a2, a1, a0};
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [63:0] exp);
    chk({tag, "_byp"}, rd_b, exp);
    chk({tag, "_nob"}, rd_n, exp);
  endtask

  task automatic chk_st(input string tag, input logic b,
                        input logic [2:0] p);
    chk({tag, "_busy_b"}, {63'd0, busy_b}, {63'd0, b});
    chk({tag, "_busy_n"}, {63'd0, busy_n}, {63'd0, b});
    chk({tag, "_ptr_b"}, {61'd0, ptr_b}, {61'd0, p});
    chk({tag, "_ptr_n"}, {61'd0, ptr_n}, {61'd0, p});
  endtask

  initial begin
    rst = 1'b1; gwe = 1'b0; rsel = '0; clr = 1'b0;
    w1sel = '0; w2sel = '0; w1data = '0; w2data = '0;
    w1e = 1'b0; w2e = 1'b0;
    #2;
    rd4(3'd1, 3'd3, 3'd5, 3'd7);
    chk_st("rst", 1'b1, 3'd0);
    chk_both("rst_rd0", 64'h0);
    rst = 1'b0;
    gwe = 1'b1;

    step(7);
    chk_st("scrub7", 1'b1, 3'd7);
    step(1);
    chk_st("scrub8", 1'b0, 3'd0);
    rd4(3'd0, 3'd1, 3'd2, 3'd3);
    chk_both("zero_lo", 64'h0);
    rd4(3'd4, 3'd5, 3'd6, 3'd7);
    chk_both("zero_hi", 64'h0);

    // Collision on address 5: w2 must win, also in the bypass path
    w1e = 1'b1; w1sel = 3'd5; w1data = 16'h1111;
    w2e = 1'b1; w2sel = 3'd5; w2data = 16'h2222;
    rd4(3'd5, 3'd5, 3'd5, 3'd5);
    chk("coll_pre_byp", rd_b, {4{16'h2222}});
    chk("coll_pre_nob", rd_n, 64'h0);
    step(1);
    w1e = 1'b0; w2e = 1'b0;
    #1;
    chk_both("coll_post", {4{16'h2222}});

    w1e = 1'b1; w1sel = 3'd2; w1data = 16'h3333;
    w2e = 1'b1; w2sel = 3'd3; w2data = 16'h4444;
    step(1);
    w1e = 1'b0; w2e = 1'b0;
    rd4(3'd3, 3'd2, 3'd3, 3'd2);
    chk_both("dist", {16'h3333, 16'h4444, 16'h3333, 16'h4444});

    w1e = 1'b1; w1sel = 3'd4; w1data = 16'h00AA;
    step(1);
    w1data = 16'h0BEE;
    rd4(3'd4, 3'd4, 3'd4, 3'd4);
    chk("byp_pre_byp", rd_b, {4{16'h0BEE}});
    chk("byp_pre_nob", rd_n, {4{16'h00AA}});
    step(1);
    w1e = 1'b0;
    #1;
    chk_both("byp_post", {4{16'h0BEE}});

    gwe = 1'b0;
    w1e = 1'b1; w1sel = 3'd1; w1data = 16'h7777;
    rd4(3'd1, 3'd1, 3'd1, 3'd1);
    chk_both("gwe0_pre", 64'h0);
    step(3);
    chk_both("gwe0_post", 64'h0);
    chk_st("gwe0_st", 1'b0, 3'd0);
    w1e = 1'b0;
    gwe = 1'b1;

    w1e = 1'b1; w2e = 1'b1;
    w1data = 16'hFFFF; w2data = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      w1sel = 3'(2 * i);
      w2sel = 3'(2 * i + 1);
      step(1);
    end
    w2e = 1'b0;
    w1sel = 3'd0; w1data = 16'h1234;
    clr = 1'b1;
    rd4(3'd0, 3'd1, 3'd6, 3'd7);
    chk_both("clr_pre", {4{16'hFFFF}});
    rd4(3'd2, 3'd3, 3'd4, 3'd5);
    chk_both("fill", {4{16'hFFFF}});
    step(1);
    clr = 1'b0;
    #1;
    chk_st("clr_edge", 1'b1, 3'd0);
    chk_both("clr_busy_rd", 64'h0);

    step(3);
    chk_st("scr3", 1'b1, 3'd3);
    gwe = 1'b0;
    step(2);
    chk_st("stall", 1'b1, 3'd3);
    gwe = 1'b1;
    step(4);
    chk_st("scr7", 1'b1, 3'd7);
    step(1);
    w1e = 1'b0;
    #1;
    chk_st("scr_done", 1'b0, 3'd0);
    rd4(3'd0, 3'd1, 3'd2, 3'd3);
    chk_both("clr_lo", 64'h0);
    rd4(3'd4, 3'd5, 3'd6, 3'd7);
    chk_both("clr_hi", 64'h0);

    w1e = 1'b1; w1sel = 3'd6; w1data = 16'h5A5A;
    step(1);
    w1e = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(5);
    chk_st("mid5", 1'b1, 3'd5);
    rst = 1'b1;
    #1;
    chk_st("mid_rst", 1'b1, 3'd0);
    rst = 1'b0;
    step(7);
    chk_st("rescr7", 1'b1, 3'd7);
    step(1);
    chk_st("rescr8", 1'b0, 3'd0);
    rd4(3'd6, 3'd0, 3'd6, 3'd3);
    chk_both("rescr_rd", 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
